rv_mem_arbiter: RTL and testbench

Single-port memory arbiter sharing one synchronous-read unified memory between the instruction-fetch requester and the load/store requester of the pipeline. Grants at most one access per cycle, data side priority, with a starvation limit guaranteeing fetch progress. Routes the one-cycle-latency read data back to the requester that issued the access. Sits between the fetch/MEM stages and the memory macro, replacing separate instruction and data memories.

---
 rtl/rv_mem_arbiter.sv | 116 +++++++++++
 tb/tb_rv_mem_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rv_mem_arbiter
// Purpose  : Shares one synchronous-read memory between instruction fetch and
//            load/store; data has priority, fetch is protected from starvation.
// Revision : 1.0 - initial release
// ============================================================================
module rv_mem_arbiter #(
    parameter int MEM_SIZE_WORDS = 256,
    parameter int MAX_DATA_BURST = 4,
    parameter int ADDR_W         = $clog2(MEM_SIZE_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rsp_valid,
    output logic [31:0]       if_rsp_data,
    input  logic              dm_req,
    input  logic [31:0]       dm_addr,
    input  logic              dm_wr_en,
    input  logic [31:0]       dm_wr_data,
    input  logic [3:0]        dm_byte_en,
    output logic              dm_gnt,
    output logic              dm_rsp_valid,
    output logic [31:0]       dm_rsp_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr_en,
    output logic [31:0]       mem_wr_data,
    output logic [3:0]        mem_byte_en,
    input  logic [31:0]       mem_rd_data
);

    localparam int               c_cnt_w     = $clog2(MAX_DATA_BURST + 1);
    localparam logic [c_cnt_w-1:0] c_burst_max = c_cnt_w'(MAX_DATA_BURST);

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_IF   = 2'd1,
        RSP_DM   = 2'd2
    } rsp_own_t;

    rsp_own_t            r_rsp_own;
    rsp_own_t            w_rsp_own_nxt;
    logic [c_cnt_w-1:0]  r_starve_cnt;
    logic [c_cnt_w-1:0]  w_starve_nxt;
    logic                w_starved;
    logic                w_if_gnt;
    logic                w_dm_gnt;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [31:0]         w_mem_wr_data;
    logic [3:0]          w_mem_byte_en;
    logic                w_unused_addr;

    // Fetch overrides data only once the burst limit has been reached.
    assign w_starved = (r_starve_cnt == c_burst_max);
    assign w_if_gnt  = if_req & (~dm_req | w_starved);
    assign w_dm_gnt  = dm_req & ~(if_req & w_starved);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_own    <= RSP_NONE;
            r_starve_cnt <= '0;
        end else begin
            r_rsp_own    <= w_rsp_own_nxt;
            r_starve_cnt <= w_starve_nxt;
        end
    end

    always_comb begin
        w_rsp_own_nxt = RSP_NONE;
        w_starve_nxt  = r_starve_cnt;
        if (w_if_gnt) begin
            w_rsp_own_nxt = RSP_IF;
        end else if (w_dm_gnt && !dm_wr_en) begin
            w_rsp_own_nxt = RSP_DM;
        end
        if (!if_req || w_if_gnt) begin
            w_starve_nxt = '0;
        end else if (w_dm_gnt && !w_starved) begin
            w_starve_nxt = r_starve_cnt + 1'b1;
        end
    end

    // Byte offset and bits above the memory depth are dropped, so addresses wrap.
    always_comb begin
        w_mem_addr    = '0;
        w_mem_wr_data = '0;
        w_mem_byte_en = '0;
        if (w_dm_gnt) begin
            w_mem_addr    = dm_addr[ADDR_W+1:2];
            w_mem_wr_data = dm_wr_data;
            w_mem_byte_en = dm_byte_en;
        end else if (w_if_gnt) begin
            w_mem_addr    = if_addr[ADDR_W+1:2];
        end
    end

    assign w_unused_addr = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                             dm_addr[31:ADDR_W+2], dm_addr[1:0]};

    assign if_gnt       = w_if_gnt;
    assign dm_gnt       = w_dm_gnt;
    assign mem_addr     = w_mem_addr;
    assign mem_wr_en    = w_dm_gnt & dm_wr_en & ~rst;
    assign mem_wr_data  = w_mem_wr_data;
    assign mem_byte_en  = w_mem_byte_en;

    assign if_rsp_valid = (r_rsp_own == RSP_IF);
    assign dm_rsp_valid = (r_rsp_own == RSP_DM);
    assign if_rsp_data  = (r_rsp_own == RSP_IF) ? mem_rd_data : 32'h0;
    assign dm_rsp_data  = (r_rsp_own == RSP_DM) ? mem_rd_data : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_rv_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_mem_arbiter
// Purpose  : Self-checking bench for rv_mem_arbiter with a memory macro model,
//            a reference arbiter and response scoreboards.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv_mem_arbiter;

    localparam int MEM_WORDS = 256;
    localparam int MAXB      = 4;
    localparam int AW        = 8;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, dm_req, dm_wr_en;
    logic [31:0]   if_addr, dm_addr, dm_wr_data;
    logic [3:0]    dm_byte_en;
    logic          if_gnt, if_rsp_valid, dm_gnt, dm_rsp_valid;
    logic [31:0]   if_rsp_data, dm_rsp_data;
    logic [AW-1:0] mem_addr;
    logic          mem_wr_en;
    logic [31:0]   mem_wr_data;
    logic [3:0]    mem_byte_en;
    logic [31:0]   mem_rd_data;

    int            cycle = 0;
    int            n_checks = 0;
    int            n_fail = 0;
    exp_t          if_q[$];
    exp_t          dm_q[$];
    logic [31:0]   ref_mem [MEM_WORDS];
    logic [31:0]   mem [MEM_WORDS];
    bit            ref_ready = 1'b0;
    int            dm_wins = 0;

    rv_mem_arbiter #(.MEM_SIZE_WORDS(MEM_WORDS), .MAX_DATA_BURST(MAXB)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .dm_req(dm_req), .dm_addr(dm_addr), .dm_wr_en(dm_wr_en),
        .dm_wr_data(dm_wr_data), .dm_byte_en(dm_byte_en), .dm_gnt(dm_gnt),
        .dm_rsp_valid(dm_rsp_valid), .dm_rsp_data(dm_rsp_data),
        .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
        .mem_byte_en(mem_byte_en), .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'h0000_0013;
        return 32'h5a5a_0000 ^ (32'(i) * 32'h0101_0301);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Memory macro: synchronous read, byte-lane writes.
    always @(posedge clk) begin
        if (cycle == 0) begin
            for (int i = 0; i < MEM_WORDS; i++) mem[i] <= init_word(i);
        end else if (mem_wr_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_byte_en[b]) mem[mem_addr][8*b +: 8] <= mem_wr_data[8*b +: 8];
        end
        mem_rd_data <= mem[mem_addr];
    end

    // Reference model: decides who should win, predicts memory drive and
    // pushes expected read data for the following cycle.
    always @(negedge clk) begin
        logic        exp_if, exp_dm;
        logic [31:0] sel, ea;
        if (cycle >= 1) begin
            if (!ref_ready) begin
                for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_word(i);
                ref_ready = 1'b1;
            end
            exp_if = if_req && (!dm_req || dm_wins >= MAXB);
            exp_dm = dm_req && !exp_if;
            sel    = exp_if ? if_addr : dm_addr;
            ea     = (exp_if || exp_dm) ? ((sel >> 2) % MEM_WORDS) : 32'h0;
            chk("if_gnt", 32'(if_gnt), 32'(exp_if));
            chk("dm_gnt", 32'(dm_gnt), 32'(exp_dm));
            chk("mem_addr", 32'(mem_addr), ea);
            chk("mem_wr_en", 32'(mem_wr_en), 32'(exp_dm && dm_wr_en && !rst));
            chk("mem_wr_data", mem_wr_data, exp_dm ? dm_wr_data : 32'h0);
            chk("mem_byte_en", 32'(mem_byte_en), exp_dm ? 32'(dm_byte_en) : 32'h0);
            if (!rst) begin
                if (exp_if) if_q.push_back('{ref_mem[ea], cycle + 1});
                if (exp_dm && !dm_wr_en) dm_q.push_back('{ref_mem[ea], cycle + 1});
                if (exp_dm && dm_wr_en)
                    for (int b = 0; b < 4; b++)
                        if (dm_byte_en[b]) ref_mem[ea][8*b +: 8] = dm_wr_data[8*b +: 8];
            end
            if (rst || !if_req || exp_if) dm_wins = 0;
            else if (exp_dm && dm_wins < MAXB) dm_wins++;
        end
    end

    // Response monitor: pops the scoreboards when a response is presented.
    always @(negedge clk) begin
        exp_t e;
        if (cycle >= 1) begin
            if (if_rsp_valid === 1'b1) begin
                if (if_q.size() > 0 && if_q[0].due == cycle) begin
                    e = if_q.pop_front();
                    chk("if_rsp_data", if_rsp_data, e.data);
                end else chk("if_rsp_unexpected", 32'(if_rsp_valid), 32'h0);
            end else begin
                chk("if_rsp_idle_data", if_rsp_data, 32'h0);
                if (if_q.size() > 0 && if_q[0].due <= cycle) begin
                    void'(if_q.pop_front());
                    chk("if_rsp_missing", 32'(if_rsp_valid), 32'h1);
                end
            end
            if (dm_rsp_valid === 1'b1) begin
                if (dm_q.size() > 0 && dm_q[0].due == cycle) begin
                    e = dm_q.pop_front();
                    chk("dm_rsp_data", dm_rsp_data, e.data);
                end else chk("dm_rsp_unexpected", 32'(dm_rsp_valid), 32'h0);
            end else begin
                chk("dm_rsp_idle_data", dm_rsp_data, 32'h0);
                if (dm_q.size() > 0 && dm_q[0].due <= cycle) begin
                    void'(dm_q.pop_front());
                    chk("dm_rsp_missing", 32'(dm_rsp_valid), 32'h1);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_addr = '0; dm_wr_en = 1'b0; dm_wr_data = '0; dm_byte_en = '0;
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(3) == 0) return $urandom;
        return (32'($urandom_range(15)) << 2) | 32'($urandom_range(3));
    endfunction

    initial begin
        string pat;
        logic  g_if, g_dm;
        pat = "DDDDIDDDDI";

        rst = 1'b1;
        if_req = 1'b1; if_addr = 32'h8;
        dm_req = 1'b1; dm_addr = 32'h40; dm_wr_en = 1'b1;
        dm_wr_data = 32'h0000_ffff; dm_byte_en = 4'hf;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_mem_wr_en", 32'(mem_wr_en), 32'h0);
            chk("rst_if_rsp_valid", 32'(if_rsp_valid), 32'h0);
            chk("rst_dm_rsp_valid", 32'(dm_rsp_valid), 32'h0);
        end
        rst = 1'b0; idle(); step();

        // Fetch only
        if_req = 1'b1; if_addr = 32'h0000_0010; #1;
        chk("fetch_gnt", 32'(if_gnt), 32'h1);
        chk("fetch_mem_addr", 32'(mem_addr), 32'h4);
        step(); idle(); #1;
        chk("fetch_rsp_valid", 32'(if_rsp_valid), 32'h1);
        chk("fetch_rsp_data", if_rsp_data, 32'h0000_0013);
        step();

        // Store then load to the same word
        dm_req = 1'b1; dm_wr_en = 1'b1; dm_addr = 32'h20;
        dm_wr_data = 32'hDEAD_BEEF; dm_byte_en = 4'hf; #1;
        chk("store_wr_en", 32'(mem_wr_en), 32'h1);
        step();
        dm_wr_en = 1'b0; #1;
        chk("store_no_rsp", 32'(dm_rsp_valid), 32'h0);
        step(); idle(); #1;
        chk("load_rsp_valid", 32'(dm_rsp_valid), 32'h1);
        chk("load_rsp_data", dm_rsp_data, 32'hDEAD_BEEF);
        step();

        // Continuous contention
        if_req = 1'b1; if_addr = 32'h0; dm_req = 1'b1; dm_wr_en = 1'b0; dm_addr = 32'h100;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("starve_pattern", 32'({if_gnt, dm_gnt}), (pat[i] == "I") ? 32'h2 : 32'h1);
            step();
        end
        idle(); step();

        // Address wrap
        dm_req = 1'b1; dm_addr = 32'h0000_0404; #1;
        chk("wrap_addr_404", 32'(mem_addr), 32'h1);
        step();
        dm_addr = 32'h0000_0406; #1;
        chk("wrap_addr_406", 32'(mem_addr), 32'h1);
        step(); idle(); step();

        // Reset during a granted load
        dm_req = 1'b1; dm_addr = 32'h30; rst = 1'b1; #1;
        chk("rst_midop_gnt", 32'(dm_gnt), 32'h1);
        step(); rst = 1'b0; idle(); #1;
        chk("rst_midop_no_rsp", 32'(dm_rsp_valid), 32'h0);
        step();

        // Randomised traffic, requests held until granted
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            g_if = if_gnt; g_dm = dm_gnt;
            @(posedge clk); #1;
            rst = ($urandom_range(99) == 0);
            if (!if_req || g_if || $urandom_range(15) == 0) begin
                if_req  = ($urandom_range(2) != 0);
                if_addr = rand_addr();
            end
            if (!dm_req || g_dm || $urandom_range(15) == 0) begin
                dm_req     = ($urandom_range(2) != 0);
                dm_addr    = rand_addr();
                dm_wr_en   = $urandom_range(1) != 0;
                dm_wr_data = $urandom;
                dm_byte_en = 4'($urandom_range(15));
            end
        end

        rst = 1'b0; idle();
        repeat (3) step();
        chk("if_q_drained", 32'(if_q.size()), 32'h0);
        chk("dm_q_drained", 32'(dm_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
